instruction_memory: RTL and testbench

- Word-addressed instruction ROM for the IF stage, with a programming write port, stall-hold and kill (NOP-injection) output selection.
- Consumes the PC and returns the 16-bit instruction for the same cycle.
- A generic 2:1 selector (LENGTH-parameterised, in1 when sel=0, in2 when sel=1) is built inside this block and used for the kill override.
- Sits between the PC register and the IF/ID pipeline register.

---
 rtl/instruction_memory.sv | 105 ++++++++++
 tb/tb_instruction_memory.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// instruction_memory: word-addressed instruction ROM for the IF stage,
// with a programming write port, stall-hold and kill (NOP) selection.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears the hold register)
//   stall       present the held instruction instead of the live read
//   kill        force the output to NOP_INST (highest priority)
//   address     word address from the PC
//   prog_we     program-write enable
//   prog_addr   program-write word address
//   prog_data   program-write data
//   instruction fetched instruction, same cycle as address

module instruction_memory_mux2 #(
  parameter int LENGTH = 16
) (
  input  logic [LENGTH-1:0] in1,
  input  logic [LENGTH-1:0] in2,
  input  logic              sel,
  output logic [LENGTH-1:0] out
);

  assign out = sel ? in2 : in1;

endmodule

module instruction_memory #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 16,
  parameter int          DEPTH     = 256,
  parameter logic [15:0] NOP_INST  = 16'h0240,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              kill,
  input  logic [ADDR_W-1:0] address,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] instruction
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INST);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] sel_stall;
  logic              rd_ok;
  logic              wr_ok;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;

  // Power-up image: every word is a bubble.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = NOP_W;
    end
  end

  // Range checks use the full address so aliasing into the array
  // cannot happen; only in-range addresses are ever truncated.
  assign rd_ok  = (address < DEPTH_A);
  assign wr_ok  = (prog_addr < DEPTH_A);
  assign rd_idx = address[IDX_W-1:0];
  assign wr_idx = prog_addr[IDX_W-1:0];

  always_comb begin
    raw = NOP_W;
    if (rd_ok) begin
      raw = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && wr_ok) begin
      mem[wr_idx] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= NOP_W;
    end else if (!stall) begin
      hold_q <= raw;
    end
  end

  assign sel_stall = stall ? hold_q : raw;

  instruction_memory_mux2 #(
    .LENGTH(DATA_W)
  ) u_kill_mux (
    .in1(sel_stall),
    .in2(NOP_W),
    .sel(kill),
    .out(instruction)
  );

endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: directed bench for instruction_memory.
// Expected words are queued on drive and popped against the output.

module tb_instruction_memory;

  localparam logic [15:0] NOP = 16'h0240;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        kill;
  logic [15:0] address;
  logic        prog_we;
  logic [15:0] prog_addr;
  logic [15:0] prog_data;
  logic [15:0] instruction;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q [$];
  string       tag_q [$];

  instruction_memory dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .kill(kill),
    .address(address),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .instruction(instruction)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change 1 after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Let combinational logic settle, then pop and compare.
  task automatic check();
    logic [15:0] exp;
    string       tag;
    #1;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    total++;
    assert (instruction === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, instruction, exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [15:0] exp);
    push(tag, exp);
    check();
  endtask

  task automatic prog(input logic [15:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    stall     = 1'b1;
    kill      = 1'b0;
    address   = 16'd0;
    prog_we   = 1'b0;
    prog_addr = 16'd0;
    prog_data = 16'd0;

    // Reset with stall held: hold register shows NOP
    tick();
    expect_now("reset_hold", NOP);
    rst   = 1'b0;
    stall = 1'b0;

    prog(16'd0, 16'h1234);
    prog(16'd1, 16'hABCD);
    prog(16'd2, 16'h5555);

    // Same-cycle reads
    address = 16'd0;
    expect_now("read0", 16'h1234);
    address = 16'd1;
    expect_now("read1", 16'hABCD);
    address = 16'd2;
    expect_now("read2", 16'h5555);
    address = 16'd3;
    expect_now("read_blank", NOP);

    // Stall hold
    address = 16'd1;
    tick();
    stall   = 1'b1;
    address = 16'd2;
    expect_now("stall_hold", 16'hABCD);
    tick();
    expect_now("stall_hold2", 16'hABCD);
    stall = 1'b0;
    expect_now("stall_release", 16'h5555);

    // Kill priority
    address = 16'd0;
    tick();
    kill = 1'b1;
    expect_now("kill", NOP);
    stall = 1'b1;
    expect_now("kill_stall", NOP);
    address = 16'd2;
    tick();
    expect_now("kill_stall_edge", NOP);
    kill = 1'b0;
    expect_now("post_kill_hold", 16'h1234);
    stall = 1'b0;
    expect_now("post_kill_live", 16'h5555);

    // Out-of-range reads and writes
    address = 16'd256;
    expect_now("oor_256", NOP);
    address = 16'hFFFF;
    expect_now("oor_ffff", NOP);
    prog(16'd300, 16'hBEEF);
    prog(16'd256, 16'hDEAD);
    address = 16'd44;
    expect_now("no_alias_44", NOP);
    address = 16'd0;
    expect_now("no_alias_0", 16'h1234);
    address = 16'd300;
    expect_now("oor_300", NOP);

    // Top in-range word
    address = 16'd255;
    expect_now("last_blank", NOP);
    prog(16'd255, 16'h0F0F);
    expect_now("last_written", 16'h0F0F);

    // Read during write
    address   = 16'd3;
    prog_we   = 1'b1;
    prog_addr = 16'd3;
    prog_data = 16'h7777;
    expect_now("rdw_old", NOP);
    tick();
    prog_we = 1'b0;
    expect_now("rdw_new", 16'h7777);
    stall = 1'b1;
    expect_now("rdw_hold_old", NOP);
    stall = 1'b0;
    tick();

    // Write during kill and stall
    kill  = 1'b1;
    stall = 1'b1;
    prog(16'd5, 16'h3C3C);
    kill  = 1'b0;
    stall = 1'b0;
    address = 16'd5;
    expect_now("write_in_kill", 16'h3C3C);

    // Reset while stalled; memory survives
    address = 16'd0;
    tick();
    stall = 1'b1;
    rst   = 1'b1;
    expect_now("pre_rst_hold", 16'h1234);
    tick();
    rst = 1'b0;
    expect_now("rst_stall", NOP);
    stall = 1'b0;
    expect_now("mem_kept", 16'h1234);
    address = 16'd1;
    expect_now("mem_kept1", 16'hABCD);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_empty: got %0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
